// File: rtl/lsu_mmio.sv
// Load/store unit for a small RV32I core: byte-addressable data memory plus memory-mapped
// LEDs, 7-segment digits, LCD word and synchronised switches, behind a valid/ready handshake.
module lsu_mmio #(
  parameter int unsigned DMEM_WORDS = 16384,
  parameter int unsigned N_HEX      = 8,
  parameter int unsigned LED_W      = 32,
  parameter int unsigned SW_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_wren,
  input  logic [2:0]           i_func3,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          o_ld_data,
  output logic                 o_fault,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [LED_W-1:0]     o_io_ledr,
  output logic [LED_W-1:0]     o_io_ledg,
  output logic [7*N_HEX-1:0]   o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);
  localparam int unsigned NG = N_HEX / 4;

  typedef enum logic [1:0] {StIdle, StRd, StResp} state_e;
  typedef enum logic [2:0] {RgnDmem, RgnLedr, RgnLedg, RgnHex, RgnLcd, RgnSw, RgnNone} rgn_e;

  function automatic rgn_e decode(input logic [31:0] a);
    rgn_e r;
    r = RgnNone;
    if (!a[28]) begin
      r = RgnDmem;
    end else if (a[31:16] == 16'h1000) begin
      if (a[15:12] == 4'h0)      r = RgnLedr;
      else if (a[15:12] == 4'h1) r = RgnLedg;
      else if (a[15:12] == 4'hF) r = RgnLcd;
      else if ({28'd0, a[15:12]} >= 32'd2 && {28'd0, a[15:12]} < NG + 32'd2) r = RgnHex;
    end else if (a[31:12] == 20'h10010) begin
      r = RgnSw;
    end
    return r;
  endfunction

  function automatic logic is_fault(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, io_rd_q, io_rd_d;
  logic                 wren_q, wren_d, fault_q, fault_d, wr_pend_q, wr_pend_d;
  logic [2:0]           func3_q, func3_d;
  logic [LED_W-1:0]     ledr_q, ledr_d, ledg_q, ledg_d;
  logic [7*N_HEX-1:0]   hex_q, hex_d;
  logic [31:0]          lcd_q, lcd_d;
  logic [SW_W-1:0]      sw_meta_q, sw_sync_q;
  logic [31:0]          dmem [DMEM_WORDS];
  logic [31:0]          mem_rd_q;

  logic                 accept, req_fault;
  rgn_e                 req_rgn, rgn_q;
  logic [3:0]           be_q;
  logic [31:0]          sdata_q, ledr_ext, ledg_ext, sw_ext, ledr_mrg, ledg_mrg, rsp_word;

  assign accept    = i_req_valid && (state_q == StIdle);
  assign req_fault = is_fault(i_func3, i_addr[1:0]);
  assign req_rgn   = decode(i_addr);
  assign rgn_q     = decode(addr_q);
  assign be_q      = byte_en(func3_q, addr_q[1:0]);
  assign sdata_q   = replicate(func3_q, wdata_q);

  always_comb begin
    ledr_ext = '0;
    ledg_ext = '0;
    sw_ext   = '0;
    ledr_ext[LED_W-1:0] = ledr_q;
    ledg_ext[LED_W-1:0] = ledg_q;
    sw_ext[SW_W-1:0]    = sw_sync_q;
  end

  assign ledr_mrg = merge(ledr_ext, sdata_q, be_q);
  assign ledg_mrg = merge(ledg_ext, sdata_q, be_q);

  // Read value for IO loads is captured at accept, which is also the RESP entry edge.
  always_comb begin
    io_rd_d = io_rd_q;
    if (accept) begin
      io_rd_d = '0;
      case (req_rgn)
        RgnLedr: io_rd_d = ledr_ext;
        RgnLedg: io_rd_d = ledg_ext;
        RgnLcd:  io_rd_d = lcd_q;
        RgnSw:   io_rd_d = sw_ext;
        RgnHex: begin
          for (int g = 0; g < int'(NG); g++) begin
            if ({28'd0, i_addr[15:12]} == 32'(g) + 32'd2) begin
              for (int k = 0; k < 4; k++) io_rd_d[8*k +: 8] = {1'b0, hex_q[7*(4*g+k) +: 7]};
            end
          end
        end
        default: io_rd_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wren_d    = wren_q;
    func3_d   = func3_q;
    fault_d   = fault_q;
    wr_pend_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = i_addr;
          wdata_d   = i_wdata;
          wren_d    = i_wren;
          func3_d   = i_func3;
          fault_d   = req_fault;
          wr_pend_d = i_wren && !req_fault;
          state_d   = (req_rgn == RgnDmem && !req_fault && !i_wren) ? StRd : StResp;
        end
      end
      StRd:    state_d = StResp;
      StResp:  if (i_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stores commit once, at the end of the first RESP cycle, from the registered request.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    lcd_d  = lcd_q;
    hex_d  = hex_q;
    if (wr_pend_q) begin
      case (rgn_q)
        RgnLedr: ledr_d = ledr_mrg[LED_W-1:0];
        RgnLedg: ledg_d = ledg_mrg[LED_W-1:0];
        RgnLcd:  lcd_d  = merge(lcd_q, sdata_q, be_q);
        RgnHex: begin
          for (int g = 0; g < int'(NG); g++) begin
            if ({28'd0, addr_q[15:12]} == 32'(g) + 32'd2) begin
              for (int k = 0; k < 4; k++) begin
                if (be_q[k]) hex_d[7*(4*g+k) +: 7] = sdata_q[8*k +: 7];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      func3_q   <= '0;
      fault_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      io_rd_q   <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      hex_q     <= '0;
      lcd_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
      func3_q   <= func3_d;
      fault_q   <= fault_d;
      wr_pend_q <= wr_pend_d;
      io_rd_q   <= io_rd_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      hex_q     <= hex_d;
      lcd_q     <= lcd_d;
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Data memory is not reset; keeping it in its own block lets it map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (accept) mem_rd_q <= dmem[i_addr[AW+1:2]];
    if (wr_pend_q && rgn_q == RgnDmem) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) dmem[addr_q[AW+1:2]][8*b +: 8] <= sdata_q[8*b +: 8];
      end
    end
  end

  assign rsp_word    = (rgn_q == RgnDmem) ? mem_rd_q : io_rd_q;
  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StResp);
  assign o_fault     = o_rsp_valid && fault_q;
  assign o_ld_data   = (o_rsp_valid && !fault_q && !wren_q) ?
                       extract(rsp_word, addr_q[1:0], func3_q) : 32'd0;
  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_hex    = hex_q;
  assign o_io_lcd    = lcd_q;

  logic unused_bits;
  assign unused_bits = ^{i_addr, addr_q, ledr_mrg, ledg_mrg};

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: a table of single transactions checked through an
// expected-response queue, plus hand sequences for stall, switch sync and reset-in-flight.
module tb_lsu_mmio;

  logic        i_clk, i_reset;
  logic        i_req_valid, o_req_ready, i_wren, o_rsp_valid, i_rsp_ready, o_fault;
  logic [31:0] i_addr, i_wdata, o_ld_data, i_io_sw, o_io_ledr, o_io_ledg, o_io_lcd;
  logic [2:0]  i_func3;
  logic [55:0] o_io_hex;

  lsu_mmio dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_wren      (i_wren),
    .i_func3     (i_func3),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_ld_data   (o_ld_data),
    .o_fault     (o_fault),
    .i_io_sw     (i_io_sw),
    .o_io_ledr   (o_io_ledr),
    .o_io_ledg   (o_io_ledg),
    .o_io_hex    (o_io_hex),
    .o_io_lcd    (o_io_lcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  func3;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [2:0] f3, input logic [31:0] ed,
                         input logic ef, input int lat);
    vec_t v;
    v.name = n; v.addr = a; v.wdata = wd; v.wren = we; v.func3 = f3;
    v.exp_data = ed; v.exp_fault = ef; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive one request, wait (bounded) for the response, compare against the queue head.
  task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] f3, input logic [31:0] ed,
                        input logic ef, input int lat, input int stall);
    exp_t e;
    int   cyc;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_addr      = a;
    i_wdata     = wd;
    i_wren      = we;
    i_func3     = f3;
    i_rsp_ready = (stall == 0);
    sb_q.push_back('{data: ed, fault: ef});
    cyc = 0;
    do begin
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      cyc++;
    end while (!o_rsp_valid && cyc < 20);
    chk({name, "/latency"}, 32'(cyc), 32'(lat));
    if (sb_q.size() == 0) begin
      chk({name, "/scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "/data"}, o_ld_data, e.data);
      chk({name, "/fault"}, {31'd0, o_fault}, {31'd0, e.fault});
    end
    if (stall > 0) begin
      // Offer a competing LEDR store while stalled; it must not be taken.
      i_req_valid = 1'b1; i_wren = 1'b1; i_addr = 32'h1000_0000;
      i_wdata = 32'hFFFF_FFFF; i_func3 = 3'b010;
      repeat (stall) begin
        @(posedge i_clk);
        #1;
        chk({name, "/stall_valid"}, {31'd0, o_rsp_valid}, 32'd1);
        chk({name, "/stall_data"}, o_ld_data, ed);
        chk({name, "/stall_ready"}, {31'd0, o_req_ready}, 32'd0);
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
    end
    @(posedge i_clk);
    #1;
    chk({name, "/rsp_done"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b0; i_req_valid = 1'b0; i_addr = '0; i_wdata = '0; i_wren = 1'b0;
    i_func3 = '0; i_rsp_ready = 1'b1; i_io_sw = 32'h1357_9BDF;

    add_vec("sw_dmem",     32'h0000_0100, 32'hAABB_CCDD, 1'b1, 3'b010, 32'h0,         1'b0, 1);
    add_vec("lbu_103",     32'h0000_0103, 32'h0,         1'b0, 3'b100, 32'h0000_00AA, 1'b0, 2);
    add_vec("lb_103",      32'h0000_0103, 32'h0,         1'b0, 3'b000, 32'hFFFF_FFAA, 1'b0, 2);
    add_vec("lh_102",      32'h0000_0102, 32'h0,         1'b0, 3'b001, 32'hFFFF_AABB, 1'b0, 2);
    add_vec("lhu_100",     32'h0000_0100, 32'h0,         1'b0, 3'b101, 32'h0000_CCDD, 1'b0, 2);
    add_vec("lb_101",      32'h0000_0101, 32'h0,         1'b0, 3'b000, 32'hFFFF_FFCC, 1'b0, 2);
    add_vec("lw_misalign", 32'h0000_0102, 32'h0,         1'b0, 3'b010, 32'h0,         1'b1, 1);
    add_vec("lh_misalign", 32'h0000_0101, 32'h0,         1'b0, 3'b001, 32'h0,         1'b1, 1);
    add_vec("st_f3_011",   32'h0000_0100, 32'h1111_1111, 1'b1, 3'b011, 32'h0,         1'b1, 1);
    add_vec("ld_f3_110",   32'h0000_0100, 32'h0,         1'b0, 3'b110, 32'h0,         1'b1, 1);
    add_vec("lw_unchg",    32'h0000_0100, 32'h0,         1'b0, 3'b010, 32'hAABB_CCDD, 1'b0, 2);
    add_vec("sh_ledr",     32'h1000_0002, 32'h0000_1234, 1'b1, 3'b001, 32'h0,         1'b0, 1);
    add_vec("sb_ledr",     32'h1000_0000, 32'h0000_0056, 1'b1, 3'b000, 32'h0,         1'b0, 1);
    add_vec("lw_ledr",     32'h1000_0000, 32'h0,         1'b0, 3'b010, 32'h1234_0056, 1'b0, 1);
    add_vec("sw_hex1",     32'h1000_3000, 32'h7F3F_067F, 1'b1, 3'b010, 32'h0,         1'b0, 1);
    add_vec("lw_hex1",     32'h1000_3000, 32'h0,         1'b0, 3'b010, 32'h7F3F_067F, 1'b0, 1);
    add_vec("lw_hex0",     32'h1000_2000, 32'h0,         1'b0, 3'b010, 32'h0,         1'b0, 1);
    add_vec("sw_unmap",    32'h1000_5000, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0,         1'b0, 1);
    add_vec("lw_unmap",    32'h1000_5000, 32'h0,         1'b0, 3'b010, 32'h0,         1'b0, 1);
    add_vec("sb_lcd",      32'h1000_F001, 32'h0000_00A5, 1'b1, 3'b000, 32'h0,         1'b0, 1);
    add_vec("lw_lcd",      32'h1000_F000, 32'h0,         1'b0, 3'b010, 32'h0000_A500, 1'b0, 1);
    add_vec("sb_ledg",     32'h1000_1003, 32'h0000_0080, 1'b1, 3'b000, 32'h0,         1'b0, 1);
    add_vec("lbu_ledg",    32'h1000_1003, 32'h0,         1'b0, 3'b100, 32'h0000_0080, 1'b0, 1);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_ld_data", o_ld_data, 32'd0);
    chk("rst_ledr", o_io_ledr, 32'd0);
    chk("rst_lcd", o_io_lcd, 32'd0);

    foreach (vecs[i]) begin
      do_req(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].wren, vecs[i].func3,
             vecs[i].exp_data, vecs[i].exp_fault, vecs[i].lat, 0);
    end

    chk("ledr_out", o_io_ledr, 32'h1234_0056);
    chk("ledg_out", o_io_ledg, 32'h8000_0000);
    chk("lcd_out", o_io_lcd, 32'h0000_A500);
    chk("hex_d4", {25'd0, o_io_hex[28 +: 7]}, 32'h7F);
    chk("hex_d5", {25'd0, o_io_hex[35 +: 7]}, 32'h06);
    chk("hex_d6", {25'd0, o_io_hex[42 +: 7]}, 32'h3F);
    chk("hex_d7", {25'd0, o_io_hex[49 +: 7]}, 32'h7F);
    chk("hex_d0_3", {4'd0, o_io_hex[27:0]}, 32'd0);

    do_req("stall_lw", 32'h0000_0100, 32'h0, 1'b0, 3'b010, 32'hAABB_CCDD, 1'b0, 2, 5);
    chk("stall_no_store", o_io_ledr, 32'h1234_0056);

    do_req("sw_before", 32'h1001_0000, 32'h0, 1'b0, 3'b010, 32'h1357_9BDF, 1'b0, 1, 0);
    i_io_sw = 32'h2468_ACE0;
    do_req("sw_1cyc", 32'h1001_0000, 32'h0, 1'b0, 3'b010, 32'h1357_9BDF, 1'b0, 1, 0);
    do_req("sw_after", 32'h1001_0000, 32'h0, 1'b0, 3'b010, 32'h2468_ACE0, 1'b0, 1, 0);

    @(negedge i_clk);
    i_req_valid = 1'b1; i_addr = 32'h0000_0100; i_wren = 1'b0; i_func3 = 3'b010;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    chk("rd_busy", {31'd0, o_req_ready}, 32'd0);
    i_reset = 1'b0;
    #1;
    chk("arst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("arst_ld_data", o_ld_data, 32'd0);
    chk("arst_ledr", o_io_ledr, 32'd0);
    chk("arst_hex", o_io_hex[31:0], 32'd0);
    chk("arst_lcd", o_io_lcd, 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("post_rst_norsp", {31'd0, o_rsp_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("post_rst_norsp2", {31'd0, o_rsp_valid}, 32'd0);
    do_req("dmem_kept", 32'h0000_0100, 32'h0, 1'b0, 3'b010, 32'hAABB_CCDD, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
